// File: rtl/idu_pipe_if.sv
// Decode-stage handshake bundle: upstream instruction offer plus downstream decoded result.
interface idu_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, rs1_data_i, rs2_data_i, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_opcode,
           out_funct3, out_funct7, out_imm, out_rs1_data, out_rs2_data, out_illegal
  );
  modport master (
    output in_valid, in_inst, in_pc, rs1_data_i, rs2_data_i, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_opcode,
           out_funct3, out_funct7, out_imm, out_rs1_data, out_rs2_data, out_illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// RV decode stage: combinational field/immediate decode captured into a two-entry
// main+skid buffer with registered in_ready, operand data sampled at accept.
module idu_pipe #(
  parameter int XLEN    = 32,
  parameter int ZERO_X0 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  idu_pipe_if.slave   bus,
  output logic [31:0] dec_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            illegal;
  } ent_t;

  ent_t        dec, m_q, s_q, m_n;
  logic        m_vld, s_vld, rdy_q;
  logic        m_vld_n, s_vld_n, ld_m, ld_s;
  logic        acc, drain, known;
  logic [31:0] inst, imm32;

  assign acc   = bus.in_valid & rdy_q;
  assign drain = m_vld & bus.out_ready;

  always_comb begin
    inst       = bus.in_inst;
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = inst[6:0];
    dec.rd     = inst[11:7];
    dec.funct3 = inst[14:12];
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.funct7 = inst[31:25];
    imm32      = '0;
    known      = 1'b1;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: imm32 = {{20{inst[31]}}, inst[31:20]};
      7'b0100011: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm32 = {inst[31:12], 12'b0};
      7'b1101111: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      7'b0110011: imm32 = '0;
      default:    known = 1'b0;
    endcase
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = !known
                | (inst[6:0] == 7'b0110011 && inst[31:25] != 7'b0000000 && inst[31:25] != 7'b0100000)
                | (inst[6:0] == 7'b1100111 && inst[14:12] != 3'b000);
    dec.rs1_data = (ZERO_X0 != 0 && inst[19:15] == 5'd0) ? '0 : bus.rs1_data_i;
    dec.rs2_data = (ZERO_X0 != 0 && inst[24:20] == 5'd0) ? '0 : bus.rs2_data_i;
  end

  // in_ready mirrors !s_vld, so an accept never coincides with a full skid.
  always_comb begin
    m_vld_n = m_vld;
    s_vld_n = s_vld;
    ld_m    = 1'b0;
    ld_s    = 1'b0;
    m_n     = dec;
    if (drain && s_vld) begin
      ld_m    = 1'b1;
      m_n     = s_q;
      s_vld_n = 1'b0;
    end else if (acc && (!m_vld || drain)) begin
      ld_m    = 1'b1;
      m_vld_n = 1'b1;
    end else if (acc) begin
      ld_s    = 1'b1;
      s_vld_n = 1'b1;
    end else if (drain) begin
      m_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld   <= 1'b0;
      s_vld   <= 1'b0;
      rdy_q   <= 1'b1;
      dec_cnt <= '0;
    end else begin
      if (drain) dec_cnt <= dec_cnt + 32'd1;
      // Flush only drops valids; stale payload is harmless once invalid.
      if (flush) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
        rdy_q <= 1'b1;
      end else begin
        m_vld <= m_vld_n;
        s_vld <= s_vld_n;
        rdy_q <= !s_vld_n;
        if (ld_m) m_q <= m_n;
        if (ld_s) s_q <= dec;
      end
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.out_valid    = m_vld;
  assign bus.out_pc       = m_q.pc;
  assign bus.out_rd       = m_q.rd;
  assign bus.out_rs1      = m_q.rs1;
  assign bus.out_rs2      = m_q.rs2;
  assign bus.out_opcode   = m_q.opcode;
  assign bus.out_funct3   = m_q.funct3;
  assign bus.out_funct7   = m_q.funct7;
  assign bus.out_imm      = m_q.imm;
  assign bus.out_rs1_data = m_q.rs1_data;
  assign bus.out_rs2_data = m_q.rs2_data;
  assign bus.out_illegal  = m_q.illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: decode vectors, skid ordering, flush and reset,
// plus a 64-bit instance for upper-bit immediate sign extension.
module tb_idu_pipe;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [31:0] cnt_a, cnt_b;
  int          total = 0, bad = 0;
  int          exp_cnt = 0;

  idu_pipe_if #(.XLEN(32)) ia ();
  idu_pipe_if #(.XLEN(64)) ib ();

  idu_pipe #(.XLEN(32), .ZERO_X0(1)) dut_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ia), .dec_cnt(cnt_a));
  idu_pipe #(.XLEN(64), .ZERO_X0(1)) dut_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ib), .dec_cnt(cnt_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one cycle; operand inputs are then scrambled
  // so a later re-read would show up as wrong captured data.
  task automatic send_a(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
    ia.in_valid = 1'b1; ia.in_inst = inst; ia.in_pc = pc;
    ia.rs1_data_i = d1; ia.rs2_data_i = d2;
    step();
    ia.in_valid = 1'b0; ia.in_inst = 32'h0;
    ia.rs1_data_i = 32'hBAD0BAD0; ia.rs2_data_i = 32'hBAD1BAD1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    ia.in_valid = 1'b0; ia.in_inst = '0; ia.in_pc = '0; ia.rs1_data_i = '0; ia.rs2_data_i = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_inst = '0; ib.in_pc = '0; ib.rs1_data_i = '0; ib.rs2_data_i = '0; ib.out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_imm", ia.out_imm, 0);
    chk("rst_illegal", ia.out_illegal, 0);
    rst_n = 1'b1;
    step();

    // addi x1,x0,-1 : rs1 index 0 forces operand to zero
    send_a(32'hFFF00093, 32'h100, 32'hDEADBEEF, 32'h1234);
    chk("addi_valid", ia.out_valid, 1);
    chk("addi_rd", ia.out_rd, 1);
    chk("addi_rs1", ia.out_rs1, 0);
    chk("addi_f3", ia.out_funct3, 0);
    chk("addi_imm", ia.out_imm, 64'hFFFFFFFF);
    chk("addi_illegal", ia.out_illegal, 0);
    chk("addi_rs1d", ia.out_rs1_data, 0);
    chk("addi_pc", ia.out_pc, 32'h100);
    step(); exp_cnt++;
    chk("addi_drained", ia.out_valid, 0);
    chk("addi_cnt", cnt_a, exp_cnt);

    send_a(32'hFFDFF06F, 32'h104, 0, 0);   // jal x0,-4
    chk("jal_imm", ia.out_imm, 64'hFFFFFFFC);
    chk("jal_op", ia.out_opcode, 7'h6F);
    chk("jal_illegal", ia.out_illegal, 0);
    step(); exp_cnt++;

    send_a(32'h002081B3, 32'h108, 32'h11111111, 32'h22222222);  // add x3,x1,x2
    chk("add_rs1d", ia.out_rs1_data, 32'h11111111);
    chk("add_rs2d", ia.out_rs2_data, 32'h22222222);
    chk("add_rs2", ia.out_rs2, 2);
    chk("add_imm", ia.out_imm, 0);
    chk("add_illegal", ia.out_illegal, 0);
    step(); exp_cnt++;

    send_a(32'hFE20AC23, 32'h10C, 0, 0);   // sw x2,-8(x1)
    chk("sw_imm", ia.out_imm, 64'hFFFFFFF8);
    chk("sw_f3", ia.out_funct3, 2);
    step(); exp_cnt++;

    send_a(32'h0000007F, 32'h110, 0, 0);
    chk("bad_op_illegal", ia.out_illegal, 1);
    chk("bad_op_imm", ia.out_imm, 0);
    step(); exp_cnt++;

    send_a(32'h022081B3, 32'h114, 0, 0);   // R-type funct7=0000001
    chk("r_f7_illegal", ia.out_illegal, 1);
    chk("r_f7", ia.out_funct7, 1);
    step(); exp_cnt++;

    send_a(32'h000110E7, 32'h118, 0, 0);   // jalr with funct3=001
    chk("jalr_f3_illegal", ia.out_illegal, 1);
    step(); exp_cnt++;
    chk("cnt_after_decode", cnt_a, exp_cnt);

    // Skid: three back-to-back offers with downstream stalled
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_inst = 32'h00100093; ia.in_pc = 32'h200; step();
    ia.in_pc = 32'h204; ia.in_inst = 32'h00200093; step();
    chk("skid_in_ready", ia.in_ready, 0);
    ia.in_pc = 32'h208; ia.in_inst = 32'h00300093; step();
    chk("skid_hold_ready", ia.in_ready, 0);
    chk("skid_hold_valid", ia.out_valid, 1);
    chk("skid_hold_pc", ia.out_pc, 32'h200);
    chk("skid_hold_imm", ia.out_imm, 1);
    ia.out_ready = 1'b1; step(); exp_cnt++;
    chk("skid_2nd_pc", ia.out_pc, 32'h204);
    chk("skid_2nd_imm", ia.out_imm, 2);
    chk("skid_ready_back", ia.in_ready, 1);
    step(); exp_cnt++;
    ia.in_valid = 1'b0;
    chk("skid_3rd_pc", ia.out_pc, 32'h208);
    chk("skid_3rd_valid", ia.out_valid, 1);
    step(); exp_cnt++;
    chk("skid_empty", ia.out_valid, 0);
    chk("skid_cnt", cnt_a, exp_cnt);

    // Flush with a same-cycle accept while main holds X
    ia.out_ready = 1'b0;
    send_a(32'h00500093, 32'h300, 0, 0);
    chk("flush_pre_valid", ia.out_valid, 1);
    ia.in_valid = 1'b1; ia.in_inst = 32'h00600093; ia.in_pc = 32'h304; flush = 1'b1;
    step();
    ia.in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", ia.out_valid, 0);
    chk("flush_ready", ia.in_ready, 1);
    ia.out_ready = 1'b1;
    step(); step();
    chk("flush_no_emit", ia.out_valid, 0);
    chk("flush_cnt", cnt_a, exp_cnt);

    // Reset with both entries full
    ia.out_ready = 1'b0;
    send_a(32'h00700093, 32'h400, 0, 0);
    send_a(32'h00800093, 32'h404, 0, 0);
    chk("full_ready", ia.in_ready, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_full_valid", ia.out_valid, 0);
    chk("rst_full_ready", ia.in_ready, 1);
    chk("rst_full_cnt", cnt_a, 0);
    chk("rst_full_pc", ia.out_pc, 0);
    ia.out_ready = 1'b1;
    step();
    chk("rst_full_no_skid", ia.out_valid, 0);

    // 64-bit instance: lui x5,0x80000 sign-extends through the upper word
    ib.in_valid = 1'b1; ib.in_inst = 32'h800002B7; ib.in_pc = 64'h1_0000_0000;
    step();
    ib.in_valid = 1'b0;
    chk("lui64_imm", ib.out_imm, 64'hFFFFFFFF80000000);
    chk("lui64_rd", ib.out_rd, 5);
    chk("lui64_pc", ib.out_pc, 64'h1_0000_0000);
    step();
    chk("lui64_cnt", cnt_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
